// File: rtl/bcd_to_binary_seq_if.sv
// Valid/ready bus for the BCD-to-binary converter: BCD operand in, binary result out.
interface bcd_to_binary_seq_if #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
);
  logic [4*DIGITS-1:0] bcd;
  logic                in_valid;
  logic                in_ready;
  logic [BIN_W-1:0]    binary;
  logic                error;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output bcd, in_valid, out_ready,
    input  in_ready, binary, error, out_valid
  );

  modport slave (
    input  bcd, in_valid, out_ready,
    output in_ready, binary, error, out_valid
  );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double dabble), one
// shift/correct step per clock, with illegal-digit detection on accept.
module bcd_to_binary_seq #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  bcd_to_binary_seq_if.slave   io_bus
);
  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e              r_state, w_state_next;
  logic [SW-1:0]       r_s;
  logic [BIN_W-1:0]    r_r;
  logic [BIN_W-1:0]    r_binary;
  logic                r_error;
  logic [CW-1:0]       r_cnt;
  logic [SW+BIN_W-1:0] w_sr_shift;
  logic [SW-1:0]       w_s_shift;
  logic [SW-1:0]       w_s_corr;
  logic                w_illegal;
  logic                w_accept;
  logic                w_last;

  assign w_accept   = (r_state == StIdle) && io_bus.in_valid;
  assign w_last     = (r_cnt == CW'(BIN_W - 1));
  assign w_sr_shift = {r_s, r_r} >> 1;
  assign w_s_shift  = w_sr_shift[SW+BIN_W-1:BIN_W];

  always_comb begin
    w_illegal = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (io_bus.bcd[4*i +: 4] > 4'd9) w_illegal = 1'b1;
    end
  end

  // Halving a BCD digit that received the carry-in bit from its neighbour
  // overshoots by 8 -> 5; subtracting 3 restores the decimal weight.
  always_comb begin
    w_s_corr = w_s_shift;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_s_shift[4*i +: 4] >= 4'd8) w_s_corr[4*i +: 4] = w_s_shift[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (io_bus.in_valid) w_state_next = w_illegal ? StDone : StConv;
      StConv:  if (w_last) w_state_next = StDone;
      StDone:  if (io_bus.out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_binary <= '0;
      r_error  <= 1'b0;
    end else if (w_accept) begin
      r_s   <= io_bus.bcd;
      r_r   <= '0;
      r_cnt <= '0;
      if (w_illegal) begin
        r_binary <= '0;
        r_error  <= 1'b1;
      end
    end else if (r_state == StConv) begin
      r_s   <= w_s_corr;
      r_r   <= w_sr_shift[BIN_W-1:0];
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_binary <= w_sr_shift[BIN_W-1:0];
        r_error  <= 1'b0;
      end
    end
  end

  assign io_bus.in_ready  = (r_state == StIdle);
  assign io_bus.out_valid = (r_state == StDone);
  assign io_bus.binary    = r_binary;
  assign io_bus.error     = r_error;
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench for bcd_to_binary_seq: 2-digit and 3-digit instances.
module tb_bcd_to_binary_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  bcd_to_binary_seq_if #(.DIGITS(2), .BIN_W(7))  a_if ();
  bcd_to_binary_seq_if #(.DIGITS(3), .BIN_W(10)) b_if ();

  bcd_to_binary_seq #(.DIGITS(2), .BIN_W(7)) u_a (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (a_if.slave)
  );

  bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) u_b (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (b_if.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic convert_a(input logic [7:0] bcd, input int exp_bin, input logic exp_err,
                           input int exp_lat, input string tag);
    int cyc;
    bit rdy_seen;
    chk({tag, "_in_ready_idle"}, 32'(a_if.in_ready), 1);
    a_if.bcd       = bcd;
    a_if.in_valid  = 1'b1;
    a_if.out_ready = 1'b1;
    step();
    a_if.in_valid = 1'b0;
    a_if.bcd      = '0;
    cyc      = 1;
    rdy_seen = 1'b0;
    while (!a_if.out_valid && cyc < 40) begin
      if (a_if.in_ready) rdy_seen = 1'b1;
      step();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_in_ready_busy"}, 32'(rdy_seen), 0);
    chk({tag, "_binary"}, 32'(a_if.binary), 32'(exp_bin));
    chk({tag, "_error"}, 32'(a_if.error), 32'(exp_err));
    step();
    chk({tag, "_out_valid_pulse"}, 32'(a_if.out_valid), 0);
    chk({tag, "_in_ready_after"}, 32'(a_if.in_ready), 1);
  endtask

  task automatic convert_b(input logic [11:0] bcd, input int exp_bin, input logic exp_err,
                           input int exp_lat, input string tag);
    int cyc;
    b_if.bcd       = bcd;
    b_if.in_valid  = 1'b1;
    b_if.out_ready = 1'b1;
    step();
    b_if.in_valid = 1'b0;
    cyc = 1;
    while (!b_if.out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_binary"}, 32'(b_if.binary), 32'(exp_bin));
    chk({tag, "_error"}, 32'(b_if.error), 32'(exp_err));
    step();
    chk({tag, "_out_valid_pulse"}, 32'(b_if.out_valid), 0);
  endtask

  initial begin
    bit ov_seen;
    rst            = 1'b1;
    a_if.bcd       = '0;
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    b_if.bcd       = '0;
    b_if.in_valid  = 1'b0;
    b_if.out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", 32'(a_if.in_ready), 1);
    chk("rst_out_valid", 32'(a_if.out_valid), 0);
    chk("rst_binary", 32'(a_if.binary), 0);
    chk("rst_error", 32'(a_if.error), 0);
    chk("rst_b_in_ready", 32'(b_if.in_ready), 1);
    rst = 1'b0;
    step();

    convert_a(8'h99, 99, 1'b0, 8, "t1_99");
    convert_a(8'h1A, 0, 1'b1, 1, "t3_1a");
    convert_a(8'hF0, 0, 1'b1, 1, "t3_f0");
    convert_a(8'h05, 5, 1'b0, 8, "t3_clear_err");

    // Result held while the consumer stalls; a second operand is ignored.
    a_if.out_ready = 1'b0;
    a_if.bcd       = 8'h42;
    a_if.in_valid  = 1'b1;
    step();
    a_if.in_valid = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("t4_out_valid_c8", 32'(a_if.out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_binary", 32'(a_if.binary), 42);
      chk("t4_hold_valid", 32'(a_if.out_valid), 1);
      chk("t4_hold_in_ready", 32'(a_if.in_ready), 0);
      a_if.in_valid = (k == 1);
      a_if.bcd      = 8'h11;
      step();
    end
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    step();
    chk("t4_release_valid", 32'(a_if.out_valid), 0);
    chk("t4_release_in_ready", 32'(a_if.in_ready), 1);
    chk("t4_release_binary", 32'(a_if.binary), 42);
    step();
    chk("t4_no_queue", 32'(a_if.in_ready), 1);

    // Reset mid-conversion discards the operand.
    a_if.bcd      = 8'h57;
    a_if.in_valid = 1'b1;
    step();
    a_if.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_in_ready", 32'(a_if.in_ready), 1);
    chk("t5_out_valid", 32'(a_if.out_valid), 0);
    chk("t5_binary", 32'(a_if.binary), 0);
    ov_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (a_if.out_valid) ov_seen = 1'b1;
      step();
    end
    chk("t5_no_output", 32'(ov_seen), 0);
    convert_a(8'h10, 10, 1'b0, 8, "t5_10");

    for (int d = 0; d < 100; d++) begin
      logic [7:0] v;
      v = {4'(d / 10), 4'(d % 10)};
      convert_a(v, d, 1'b0, 8, "t2_sweep");
    end

    convert_b(12'h999, 999, 1'b0, 11, "t6_999");
    convert_b(12'h000, 0, 1'b0, 11, "t6_000");
    convert_b(12'h0B0, 0, 1'b1, 1, "t6_illegal");
    convert_b(12'h512, 512, 1'b0, 11, "t6_512");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
